// File: rtl/sprite_palette_bank.sv
// Per-pose sprite palette with a two-stage lookup pipeline, write bypass,
// transparent-index handling and a blinking hit-flash overlay.
module sprite_palette_bank #(
  parameter int NUM_POSES       = 10,
  parameter int IDX_W           = 4,
  parameter int COLOR_W         = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FLASH_LEN       = 32,
  parameter int FLASH_HALF      = 4,
  localparam int PW = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 req_valid,
  input  logic [PW-1:0]        pose_sel,
  input  logic [IDX_W-1:0]     index,
  input  logic                 wr_en,
  input  logic [PW-1:0]        wr_pose,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 flash_start,
  output logic                 out_valid,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 transparent,
  output logic                 flash_active
);

  localparam int DEPTH       = 2 ** IDX_W;
  localparam int NUM_ENTRIES = NUM_POSES * DEPTH;
  localparam int AW          = PW + IDX_W;
  localparam int RGB_W       = 3 * COLOR_W;
  localparam int CW          = $clog2(FLASH_LEN + 1);

  localparam logic [PW:0]      POSE_LIMIT = (PW + 1)'(NUM_POSES);
  localparam logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(TRANSPARENT_IDX);
  localparam logic [CW-1:0]    FLASH_LOAD = CW'(FLASH_LEN);
  localparam logic [CW-1:0]    FLASH_STEP = CW'(FLASH_HALF);

  // Palette storage: data array without reset, plus one valid bit per entry
  // that reset clears, so a cleared entry reads as 0 until it is rewritten.
  logic [RGB_W-1:0]       palette_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] entry_valid_reg;

  logic          wr_ok;
  logic [AW-1:0] wr_addr;

  assign wr_ok   = wr_en && ({1'b0, wr_pose} < POSE_LIMIT);
  assign wr_addr = {wr_pose, wr_idx};

  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      palette_mem[wr_addr] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      entry_valid_reg <= '0;
    end else if (wr_ok) begin
      entry_valid_reg[wr_addr] <= 1'b1;
    end
  end

  // Stage 1: capture the request.
  logic             s1_valid_reg;
  logic [PW-1:0]    s1_pose_reg;
  logic [IDX_W-1:0] s1_index_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_pose_reg  <= '0;
      s1_index_reg <= '0;
    end else begin
      s1_valid_reg <= req_valid;
      s1_pose_reg  <= pose_sel;
      s1_index_reg <= index;
    end
  end

  // Stage 2: read the entry, forwarding a write that lands on the same edge.
  logic             rd_pose_ok;
  logic [AW-1:0]    rd_addr;
  logic             bypass;
  logic             transp_pix;
  logic [RGB_W-1:0] stored_rgb;

  assign rd_pose_ok = ({1'b0, s1_pose_reg} < POSE_LIMIT);
  assign rd_addr    = {s1_pose_reg, s1_index_reg};
  assign bypass     = wr_ok && (wr_addr == rd_addr);
  assign transp_pix = !rd_pose_ok || (s1_index_reg == TRANSP_IDX);

  always_comb begin
    stored_rgb = '0;
    if (bypass) begin
      stored_rgb = wr_rgb;
    end else if (rd_pose_ok && entry_valid_reg[rd_addr]) begin
      stored_rgb = palette_mem[rd_addr];
    end
  end

  // Flash counter and blink phase.
  logic [CW-1:0] flash_cnt_reg;
  logic [CW-1:0] flash_cnt_next;
  logic [CW-1:0] flash_elapsed;
  logic [CW-1:0] flash_phase;
  logic          flash_on;
  logic          flash_active_reg;

  always_comb begin
    flash_cnt_next = flash_cnt_reg;
    if (flash_start) begin
      flash_cnt_next = FLASH_LOAD;
    end else if (flash_cnt_reg != '0) begin
      flash_cnt_next = flash_cnt_reg - 1'b1;
    end
  end

  // Phase uses the counter value that appears alongside the registered
  // pixel, so the blink lines up with flash_active on the same cycle.
  assign flash_elapsed = FLASH_LOAD - flash_cnt_next;
  assign flash_phase   = flash_elapsed / FLASH_STEP;
  assign flash_on      = (flash_cnt_next != '0) && !flash_phase[0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt_reg    <= '0;
      flash_active_reg <= 1'b0;
    end else begin
      flash_cnt_reg    <= flash_cnt_next;
      flash_active_reg <= (flash_cnt_next != '0);
    end
  end

  // Output registers.
  logic out_valid_reg;
  logic transparent_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_reg   <= 1'b0;
      transparent_reg <= 1'b0;
    end else begin
      out_valid_reg   <= s1_valid_reg;
      transparent_reg <= s1_valid_reg && transp_pix;
    end
  end

  // Channel 0 is red (MSBs of the packed colour), 2 is blue.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [COLOR_W-1:0] stored_chan;
      logic [COLOR_W-1:0] chan_next;
      logic [COLOR_W-1:0] chan_reg;

      assign stored_chan = stored_rgb[(2-gi)*COLOR_W +: COLOR_W];

      always_comb begin
        chan_next = '0;
        if (s1_valid_reg && !transp_pix) begin
          chan_next = flash_on ? {COLOR_W{1'b1}} : stored_chan;
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          chan_reg <= '0;
        end else begin
          chan_reg <= chan_next;
        end
      end
    end
  endgenerate

  assign out_valid    = out_valid_reg;
  assign transparent  = transparent_reg;
  assign flash_active = flash_active_reg;
  assign red          = g_chan[0].chan_reg;
  assign green        = g_chan[1].chan_reg;
  assign blue         = g_chan[2].chan_reg;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: lookups, bypass, flash blinking
// and reset behaviour, with hand-derived expectations.
module tb_sprite_palette_bank;

  logic        Clk;
  logic        Reset_n;
  logic        req_valid;
  logic [3:0]  pose_sel;
  logic [3:0]  index;
  logic        wr_en;
  logic [3:0]  wr_pose;
  logic [3:0]  wr_idx;
  logic [11:0] wr_rgb;
  logic        flash_start;
  logic        out_valid;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        transparent;
  logic        flash_active;

  int tests  = 0;
  int failed = 0;

  sprite_palette_bank dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .pose_sel     (pose_sel),
    .index        (index),
    .wr_en        (wr_en),
    .wr_pose      (wr_pose),
    .wr_idx       (wr_idx),
    .wr_rgb       (wr_rgb),
    .flash_start  (flash_start),
    .out_valid    (out_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .transparent  (transparent),
    .flash_active (flash_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // {out_valid, transparent, red, green, blue}
  function automatic logic [31:0] word();
    return {18'b0, out_valid, transparent, red, green, blue};
  endfunction

  function automatic logic [31:0] mk(input logic v, input logic t, input logic [11:0] rgb);
    return {18'b0, v, t, rgb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] p, input logic [3:0] i, input logic [11:0] rgb);
    wr_en   = 1'b1;
    wr_pose = p;
    wr_idx  = i;
    wr_rgb  = rgb;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [3:0] p, input logic [3:0] i,
                        input logic [31:0] exp);
    req_valid = 1'b1;
    pose_sel  = p;
    index     = i;
    tick();
    req_valid = 1'b0;
    check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    tick();
    check(tag, word(), exp);
    tick();
    check({tag, "_idle"}, word(), 32'd0);
  endtask

  initial begin
    int cnt;
    logic on;
    Reset_n     = 1'b0;
    req_valid   = 1'b0;
    pose_sel    = '0;
    index       = '0;
    wr_en       = 1'b0;
    wr_pose     = '0;
    wr_idx      = '0;
    wr_rgb      = '0;
    flash_start = 1'b0;

    tick();
    tick();
    check("reset_out", word(), 32'd0);
    check("reset_flash", {31'b0, flash_active}, 32'd0);
    Reset_n = 1'b1;
    tick();

    // Basic loads and lookups
    write_entry(4'd3, 4'd5, 12'hA81);
    write_entry(4'd2, 4'd0, 12'hF0F);
    write_entry(4'd1, 4'd9, 12'h456);
    lookup("p3i5", 4'd3, 4'd5, mk(1'b1, 1'b0, 12'hA81));
    lookup("p2i0_transp", 4'd2, 4'd0, mk(1'b1, 1'b1, 12'h000));
    lookup("p12_range", 4'd12, 4'd7, mk(1'b1, 1'b1, 12'h000));
    lookup("p10_range", 4'd10, 4'd7, mk(1'b1, 1'b1, 12'h000));
    lookup("p0i3_empty", 4'd0, 4'd3, mk(1'b1, 1'b0, 12'h000));
    lookup("p1i9_old", 4'd1, 4'd9, mk(1'b1, 1'b0, 12'h456));
    write_entry(4'd9, 4'd5, 12'h777);
    lookup("p9i5_last", 4'd9, 4'd5, mk(1'b1, 1'b0, 12'h777));

    // Out-of-range writes change nothing
    write_entry(4'd12, 4'd5, 12'hFFF);
    write_entry(4'd10, 4'd5, 12'hEEE);
    lookup("p3i5_after_oor", 4'd3, 4'd5, mk(1'b1, 1'b0, 12'hA81));

    // Write on the same edge stage 2 reads: bypass
    req_valid = 1'b1; pose_sel = 4'd1; index = 4'd9;
    tick();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_pose = 4'd1; wr_idx = 4'd9; wr_rgb = 12'h123;
    tick();
    wr_en = 1'b0;
    check("bypass_same", word(), mk(1'b1, 1'b0, 12'h123));
    tick();
    // Write to a neighbouring entry must not be forwarded
    req_valid = 1'b1; pose_sel = 4'd1; index = 4'd9;
    tick();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_pose = 4'd1; wr_idx = 4'd8; wr_rgb = 12'h777;
    tick();
    wr_en = 1'b0;
    check("bypass_other", word(), mk(1'b1, 1'b0, 12'h123));
    tick();
    lookup("p1i8_new", 4'd1, 4'd8, mk(1'b1, 1'b0, 12'h777));

    // Back-to-back requests
    req_valid = 1'b1; pose_sel = 4'd3; index = 4'd5;
    tick();
    pose_sel = 4'd1; index = 4'd9;
    tick();
    check("b2b_0", word(), mk(1'b1, 1'b0, 12'hA81));
    pose_sel = 4'd2; index = 4'd0;
    tick();
    check("b2b_1", word(), mk(1'b1, 1'b0, 12'h123));
    req_valid = 1'b0;
    tick();
    check("b2b_2", word(), mk(1'b1, 1'b1, 12'h000));
    tick();
    check("b2b_end", word(), 32'd0);

    // Flash: single start with continuous lookups
    flash_start = 1'b1;
    req_valid = 1'b1; pose_sel = 4'd3; index = 4'd5;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) flash_start = 1'b0;
      check($sformatf("flash1_act_k%0d", k), {31'b0, flash_active}, {31'b0, (k <= 32)});
      if (k >= 2) begin
        cnt = (k <= 32) ? 33 - k : 0;
        on  = (cnt != 0) && ((((32 - cnt) / 4) % 2) == 0);
        check($sformatf("flash1_pix_k%0d", k), word(),
              on ? mk(1'b1, 1'b0, 12'hFFF) : mk(1'b1, 1'b0, 12'hA81));
      end
    end
    req_valid = 1'b0;
    tick();
    tick();

    // Flash: restart 10 cycles after the first start extends to 42 cycles
    flash_start = 1'b1;
    req_valid = 1'b1; pose_sel = 4'd3; index = 4'd5;
    for (int k = 1; k <= 45; k++) begin
      tick();
      flash_start = (k == 10);
      check($sformatf("flash2_act_k%0d", k), {31'b0, flash_active}, {31'b0, (k <= 42)});
      if (k >= 2) begin
        cnt = (k <= 10) ? 33 - k : ((k <= 42) ? 43 - k : 0);
        on  = (cnt != 0) && ((((32 - cnt) / 4) % 2) == 0);
        check($sformatf("flash2_pix_k%0d", k), word(),
              on ? mk(1'b1, 1'b0, 12'hFFF) : mk(1'b1, 1'b0, 12'hA81));
      end
    end
    req_valid = 1'b0;
    tick();
    tick();

    // Transparent index ignores flash; then reset mid-stream
    flash_start = 1'b1;
    req_valid = 1'b1; pose_sel = 4'd2; index = 4'd0;
    tick();
    flash_start = 1'b0;
    pose_sel = 4'd3; index = 4'd5;
    tick();
    check("flash_transp", word(), mk(1'b1, 1'b1, 12'h000));
    tick();
    check("flash_on_pix", word(), mk(1'b1, 1'b0, 12'hFFF));
    #1;
    Reset_n = 1'b0;
    #1;
    check("rst_async_out", word(), 32'd0);
    check("rst_async_flash", {31'b0, flash_active}, 32'd0);
    tick();
    check("rst_hold_0", word(), 32'd0);
    tick();
    check("rst_hold_1", word(), 32'd0);
    Reset_n = 1'b1;
    tick();
    check("rst_no_stale", word(), 32'd0);
    tick();
    check("rst_first_req", word(), mk(1'b1, 1'b0, 12'h000));
    check("rst_flash_clr", {31'b0, flash_active}, 32'd0);
    req_valid = 1'b0;
    tick();
    tick();
    lookup("rst_p1i9_zero", 4'd1, 4'd9, mk(1'b1, 1'b0, 12'h000));
    write_entry(4'd3, 4'd5, 12'h5A5);
    lookup("rst_p3i5_rewr", 4'd3, 4'd5, mk(1'b1, 1'b0, 12'h5A5));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
